// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the raster timing generator.
// Defaults describe 640x480@60 with active-low syncs. Counters are CNT_W bits wide,
// so any axis total must fit in 2**CNT_W positions.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam bit DEF_SYNC_POL = 1'b0;

    function automatic bit fits_cnt(input int total);
        return total <= (1 << CNT_W);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator, the painters and the pin drivers.
//   pix_ce            pixel clock-enable into the generator
//   sx, sy            current column / line
//   de, line_start, vblank_start   combinational raster qualifiers
//   paint_r/g/b       painter colour into the generator
//   vga_r/g/b, vga_hs, vga_vs      registered pin outputs
// master = timing generator, slave = the surroundings (painters, pins, ce source).
interface vga_timing_gen_if;
    logic       pix_ce;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       line_start;
    logic       vblank_start;
    logic [3:0] paint_r;
    logic [3:0] paint_g;
    logic [3:0] paint_b;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;

    modport master (
        input  pix_ce, paint_r, paint_g, paint_b,
        output sx, sy, de, line_start, vblank_start,
               vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        output pix_ce, paint_r, paint_g, paint_b,
        input  sx, sy, de, line_start, vblank_start,
               vga_r, vga_g, vga_b, vga_hs, vga_vs
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync window decode.
//   clk, rst_n   clock, async active-low reset
//   en_i         advance by one position (wraps at TOTAL-1)
//   cnt_o        current position
//   active_o     position < ACTIVE
//   sync_o       ACTIVE+FP <= position < ACTIVE+FP+SYNC (raw, before polarity)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             active_o,
    output logic             sync_o
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    if (!fits_cnt(TOTAL)) begin : g_total_check
        $error("vga_axis_counter: axis total %0d exceeds counter range", TOTAL);
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    int               pos;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Window compares in int so ACTIVE+FP+SYNC == 2**CNT_W cannot wrap to zero.
    assign pos      = int'(cnt_q);
    assign active_o = pos < ACTIVE;
    assign sync_o   = (pos >= ACTIVE + FP) && (pos < ACTIVE + FP + SYNC);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: sx/sy counters, de and frame/line strobes, and a one-stage
// output register so colour and syncs reach the pins on the same pix_ce.
//   clk, rst_n   clock, async active-low reset
//   bus          vga_timing_gen_if master: pix_ce/paint_* in, raster and pin signals out
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VBLANK = CNT_W'(V_ACTIVE);

    logic [CNT_W-1:0] sx, sy;
    logic             h_wrap, h_act, v_act, hs_raw, vs_raw, de;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .en_i(bus.pix_ce),
        .cnt_o(sx), .active_o(h_act), .sync_o(hs_raw)
    );

    // The line counter steps only on the pixel that ends a line.
    assign h_wrap = bus.pix_ce && (sx == H_LAST);

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .en_i(h_wrap),
        .cnt_o(sy), .active_o(v_act), .sync_o(vs_raw)
    );

    assign de = h_act && v_act;

    logic [3:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic       hs_q, vs_q, hs_d, vs_d;

    always_comb begin
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (bus.pix_ce) begin
            // Blank outside the active area whatever the painter drives.
            r_d  = de ? bus.paint_r : 4'h0;
            g_d  = de ? bus.paint_g : 4'h0;
            b_d  = de ? bus.paint_b : 4'h0;
            hs_d = hs_raw ~^ SYNC_POL;
            vs_d = vs_raw ~^ SYNC_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= 4'h0;
            g_q  <= 4'h0;
            b_q  <= 4'h0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign bus.sx           = sx;
    assign bus.sy           = sy;
    assign bus.de           = de;
    assign bus.line_start   = bus.pix_ce && (sx == '0);
    assign bus.vblank_start = bus.pix_ce && (sx == '0) && (sy == V_VBLANK);
    assign bus.vga_r        = r_q;
    assign bus.vga_g        = g_q;
    assign bus.vga_b        = b_q;
    assign bus.vga_hs       = hs_q;
    assign bus.vga_vs       = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b1;
    logic [3:0] pr = 4'h0, pg = 4'h0, pb = 4'h0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();

    assign if_d.pix_ce  = pix_ce;
    assign if_d.paint_r = pr;
    assign if_d.paint_g = pg;
    assign if_d.paint_b = pb;
    assign if_s.pix_ce  = pix_ce;
    assign if_s.paint_r = pr;
    assign if_s.paint_g = pg;
    assign if_s.paint_b = pb;

    // Full 640x480 instance for line-level timing.
    vga_timing_gen dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.master));

    // Tiny raster (25 x 13) so whole frames fit in a short run.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.master));

    typedef struct {int ha, hf, hs, hb, va, vf, vs, vb;} cfg_t;
    typedef struct {int x, y; logic [3:0] r, g, b; logic hs, vs;} st_t;
    typedef logic [36:0] vec_t;

    cfg_t cd, cs;
    st_t  sd, ss;
    vec_t q_d[$];
    vec_t q_s[$];

    int errors = 0;
    int checks = 0;

    function automatic st_t rst_state();
        st_t s;
        s.x = 0; s.y = 0; s.r = 4'h0; s.g = 4'h0; s.b = 4'h0; s.hs = 1'b1; s.vs = 1'b1;
        return s;
    endfunction

    function automatic st_t step(cfg_t c, st_t s, logic ce, logic rn,
                                 logic [3:0] r, logic [3:0] g, logic [3:0] b);
        st_t  n;
        logic de;
        int   ht, vt;
        n  = s;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        de = (s.x < c.ha) && (s.y < c.va);
        if (!rn) begin
            n = rst_state();
        end else if (ce) begin
            n.r  = de ? r : 4'h0;
            n.g  = de ? g : 4'h0;
            n.b  = de ? b : 4'h0;
            n.hs = !((s.x >= c.ha + c.hf) && (s.x < c.ha + c.hf + c.hs));
            n.vs = !((s.y >= c.va + c.vf) && (s.y < c.va + c.vf + c.vs));
            if (s.x == ht - 1) begin
                n.x = 0;
                n.y = (s.y == vt - 1) ? 0 : s.y + 1;
            end else begin
                n.x = s.x + 1;
            end
        end
        return n;
    endfunction

    function automatic vec_t expect_vec(cfg_t c, st_t s, logic ce);
        logic de, ls, vbs;
        de  = (s.x < c.ha) && (s.y < c.va);
        ls  = ce && (s.x == 0);
        vbs = ce && (s.x == 0) && (s.y == c.va);
        return {10'(s.x), 10'(s.y), de, ls, vbs, s.hs, s.vs, s.r, s.g, s.b};
    endfunction

    wire vec_t act_d = {if_d.sx, if_d.sy, if_d.de, if_d.line_start, if_d.vblank_start,
                        if_d.vga_hs, if_d.vga_vs, if_d.vga_r, if_d.vga_g, if_d.vga_b};
    wire vec_t act_s = {if_s.sx, if_s.sy, if_s.de, if_s.line_start, if_s.vblank_start,
                        if_s.vga_hs, if_s.vga_vs, if_s.vga_r, if_s.vga_g, if_s.vga_b};

    task automatic push_expected();
        q_d.push_back(expect_vec(cd, sd, pix_ce));
        q_s.push_back(expect_vec(cs, ss, pix_ce));
    endtask

    // One clock: advance both models with the inputs the edge saw, then drive the next inputs.
    task automatic cycle(input logic ce_n, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        @(posedge clk);
        #1;
        sd = step(cd, sd, pix_ce, rst_n, pr, pg, pb);
        ss = step(cs, ss, pix_ce, rst_n, pr, pg, pb);
        pix_ce = ce_n;
        pr = r; pg = g; pb = b;
        push_expected();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        vec_t e;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            checks++;
            if (act_d !== e) begin
                errors++;
                $display("FAIL sb_640x480 t=%0t got=%h expected=%h", $time, act_d, e);
            end
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            checks++;
            if (act_s !== e) begin
                errors++;
                $display("FAIL sb_small t=%0t got=%h expected=%h", $time, act_s, e);
            end
        end
    end

    // Event statistics for the hand-computed timing checks.
    logic stat_en = 1'b0;
    int   neg_idx = 0;
    int   hs_low_d, first_hs_sx, ls_d, r_f_d, hs_low_s, vs_low_s;
    int   vbs_cnt, last_vbs, vbs_period, vbs_run, vbs_max_run;

    task automatic clear_stats();
        hs_low_d = 0; first_hs_sx = -1; ls_d = 0; r_f_d = 0;
        hs_low_s = 0; vs_low_s = 0;
        vbs_cnt = 0; last_vbs = -1; vbs_period = -1; vbs_run = 0; vbs_max_run = 0;
    endtask

    always @(negedge clk) begin
        neg_idx <= neg_idx + 1;
        if (stat_en) begin
            if (!if_d.vga_hs) begin
                hs_low_d++;
                if (first_hs_sx < 0) first_hs_sx = int'(if_d.sx);
            end
            if (if_d.line_start)   ls_d++;
            if (if_d.vga_r == 4'hF) r_f_d++;
            if (!if_s.vga_hs) hs_low_s++;
            if (!if_s.vga_vs) vs_low_s++;
            if (if_s.vblank_start) begin
                vbs_cnt++;
                if (last_vbs >= 0) vbs_period = neg_idx - last_vbs;
                last_vbs = neg_idx;
                vbs_run++;
                if (vbs_run > vbs_max_run) vbs_max_run = vbs_run;
            end else begin
                vbs_run = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        cd = '{DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
               DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP};
        cs = '{16, 2, 4, 3, 8, 1, 2, 2};
        sd = rst_state();
        ss = rst_state();
        clear_stats();

        // Reset held with pix_ce high and a bright painter.
        repeat (10) cycle(1'b1, 4'hF, 4'hF, 4'hF);
        chk("rst_sx",     int'(if_d.sx), 0);
        chk("rst_sy",     int'(if_d.sy), 0);
        chk("rst_hs",     int'(if_d.vga_hs), 1);
        chk("rst_vs",     int'(if_d.vga_vs), 1);
        chk("rst_rgb",    int'({if_d.vga_r, if_d.vga_g, if_d.vga_b}), 0);
        chk("rst_de",     int'(if_d.de), 1);
        chk("rst_ls",     int'(if_d.line_start), 1);
        chk("rst_vbs",    int'(if_d.vblank_start), 0);

        // pix_ce permanently high, constant white painter.
        rst_n = 1'b1;
        clear_stats();
        stat_en = 1'b1;
        repeat (1700) cycle(1'b1, 4'hF, 4'hF, 4'hF);
        @(negedge clk); #1;
        stat_en = 1'b0;
        chk("hs_low_cycles_2lines", hs_low_d, 192);
        chk("hs_first_low_sx",      first_hs_sx, 657);
        chk("line_start_count",     ls_d, 3);
        chk("rgb_white_cycles",     r_f_d, 1380);
        chk("small_hs_low",         hs_low_s, 272);
        chk("small_vs_low",         vs_low_s, 250);
        chk("small_vblank_count",   vbs_cnt, 5);
        chk("small_frame_ce",       vbs_period, 325);

        // pix_ce one clock in four, varying painter colour.
        clear_stats();
        stat_en = 1'b1;
        for (int i = 0; i < 2600; i++) begin
            cycle((i % 4) == 3, 4'(i), 4'(i + 5), 4'(i * 3));
        end
        @(negedge clk); #1;
        stat_en = 1'b0;
        chk("ce4_vblank_count",  vbs_cnt, 2);
        chk("ce4_frame_clks",    vbs_period, 1300);
        chk("ce4_strobe_width",  vbs_max_run, 1);
        chk("ce4_end_sx",        int'(if_d.sx), 750);
        chk("ce4_end_sy",        int'(if_d.sy), 2);
        chk("ce4_small_end_sx",  int'(if_s.sx), 0);
        chk("ce4_small_end_sy",  int'(if_s.sy), 3);

        // Async reset mid-line, between clock edges.
        rst_n = 1'b0;
        repeat (3) cycle(1'b1, 4'hF, 4'hF, 4'hF);
        rst_n = 1'b1;
        repeat (1100) cycle(1'b1, 4'hF, 4'hF, 4'hF);
        #2;
        chk("pre_async_sx", int'(if_d.sx), 300);
        chk("pre_async_sy", int'(if_d.sy), 1);
        chk("pre_async_r",  int'(if_d.vga_r), 15);
        rst_n = 1'b0;
        #1;
        chk("async_sx", int'(if_d.sx), 0);
        chk("async_sy", int'(if_d.sy), 0);
        chk("async_hs", int'(if_d.vga_hs), 1);
        chk("async_vs", int'(if_d.vga_vs), 1);
        chk("async_rgb", int'({if_d.vga_r, if_d.vga_g, if_d.vga_b}), 0);
        q_d.delete();
        q_s.delete();
        sd = rst_state();
        ss = rst_state();
        push_expected();
        repeat (3) cycle(1'b1, 4'h3, 4'h6, 4'h9);
        rst_n = 1'b1;
        repeat (2) cycle(1'b1, 4'h3, 4'h6, 4'h9);
        chk("restart_sx", int'(if_d.sx), 2);
        chk("restart_sy", int'(if_d.sy), 0);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
